// File: rtl/axi_riscv_lrsc_table.sv
// ---------------------------------------------------------------------------
// axi_riscv_lrsc_table : LR/SC reservation table with per-ID slots, granule
//                        matching, round-robin eviction and optional timeout.
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module axi_riscv_lrsc_table #(
  parameter int ADDR_WIDTH     = 64,
  parameter int ID_WIDTH       = 5,
  parameter int NUM_SLOTS      = 4,
  parameter int RES_GRANULE    = 8,
  parameter int TIMEOUT_CYCLES = 0
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           req_valid_i,
  output logic                           req_ready_o,
  input  logic [1:0]                     req_op_i,
  input  logic [ID_WIDTH-1:0]            req_id_i,
  input  logic [ADDR_WIDTH-1:0]          req_addr_i,
  output logic                           rsp_valid_o,
  input  logic                           rsp_ready_i,
  output logic                           rsp_sc_ok_o,
  output logic [ID_WIDTH-1:0]            rsp_id_o,
  output logic [$clog2(NUM_SLOTS+1)-1:0] occupancy_o
);

  localparam int c_gran_shift = $clog2(RES_GRANULE);
  localparam int c_gran_w     = ADDR_WIDTH - c_gran_shift;
  localparam int c_idx_w      = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
  localparam int c_age_w      = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int c_age_max    = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
  localparam int c_occ_w      = $clog2(NUM_SLOTS + 1);

  localparam logic [1:0] c_op_lr  = 2'b00;
  localparam logic [1:0] c_op_sc  = 2'b01;
  localparam logic [1:0] c_op_wr  = 2'b10;

  logic [NUM_SLOTS-1:0] r_valid;
  logic [ID_WIDTH-1:0]  r_id   [NUM_SLOTS];
  logic [c_gran_w-1:0]  r_gran [NUM_SLOTS];
  logic [c_age_w-1:0]   r_age  [NUM_SLOTS];
  logic [c_idx_w-1:0]   r_evict_ptr;
  logic                 r_rsp_valid;
  logic                 r_rsp_sc_ok;
  logic [ID_WIDTH-1:0]  r_rsp_id;

  logic [NUM_SLOTS-1:0] w_valid_nxt;
  logic [ID_WIDTH-1:0]  w_id_nxt   [NUM_SLOTS];
  logic [c_gran_w-1:0]  w_gran_nxt [NUM_SLOTS];
  logic [c_age_w-1:0]   w_age_nxt  [NUM_SLOTS];
  logic [c_idx_w-1:0]   w_ptr_nxt;

  logic [c_gran_w-1:0]  w_req_gran;
  logic [NUM_SLOTS-1:0] w_hit_id;
  logic [NUM_SLOTS-1:0] w_hit_gran;
  logic [NUM_SLOTS-1:0] w_expire;
  logic                 w_sc_ok;
  logic                 w_accept;
  logic                 w_free_found;
  logic [c_idx_w-1:0]   w_free_idx;
  logic [c_idx_w-1:0]   w_id_idx;
  logic [c_idx_w-1:0]   w_lr_idx;
  logic                 w_evict;
  logic [c_occ_w-1:0]   w_occ;

  assign w_req_gran  = req_addr_i[ADDR_WIDTH-1:c_gran_shift];
  assign req_ready_o = !r_rsp_valid || rsp_ready_i;
  assign w_accept    = req_valid_i && req_ready_o;
  assign w_sc_ok     = |(w_hit_id & w_hit_gran);

  generate
    if (c_gran_shift > 0) begin : g_addr_lsb
      logic w_unused_addr_lsb;
      assign w_unused_addr_lsb = ^req_addr_i[c_gran_shift-1:0];
    end
    for (genvar gi = 0; gi < NUM_SLOTS; gi++) begin : g_slot
      if (TIMEOUT_CYCLES > 0) begin : g_timeout
        assign w_expire[gi] = r_valid[gi] && (r_age[gi] == c_age_w'(c_age_max));
      end else begin : g_no_timeout
        assign w_expire[gi] = 1'b0;
      end
    end
  endgenerate

  always_comb begin
    w_hit_id   = '0;
    w_hit_gran = '0;
    w_occ      = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      w_hit_id[i]   = r_valid[i] && (r_id[i] == req_id_i);
      w_hit_gran[i] = r_valid[i] && (r_gran[i] == w_req_gran);
      w_occ         = w_occ + c_occ_w'(r_valid[i]);
    end
  end

  // LR slot choice: own slot first, then lowest free slot, else evict.
  always_comb begin
    w_free_found = 1'b0;
    w_free_idx   = '0;
    w_id_idx     = '0;
    w_lr_idx     = r_evict_ptr;
    w_evict      = 1'b0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (!r_valid[i]) begin
        w_free_found = 1'b1;
        w_free_idx   = c_idx_w'(i);
      end
      if (w_hit_id[i]) w_id_idx = c_idx_w'(i);
    end
    if (|w_hit_id)         w_lr_idx = w_id_idx;
    else if (w_free_found) w_lr_idx = w_free_idx;
    else                   w_evict  = 1'b1;
  end

  // Ageing is applied first so that an LR to the same slot overrides expiry.
  always_comb begin
    w_valid_nxt = r_valid;
    w_id_nxt    = r_id;
    w_gran_nxt  = r_gran;
    w_age_nxt   = r_age;
    w_ptr_nxt   = r_evict_ptr;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (TIMEOUT_CYCLES > 0 && r_valid[i]) begin
        if (w_expire[i]) w_valid_nxt[i] = 1'b0;
        else             w_age_nxt[i]   = r_age[i] + c_age_w'(1);
      end
    end
    if (w_accept) begin
      case (req_op_i)
        c_op_lr: begin
          w_valid_nxt[w_lr_idx] = 1'b1;
          w_id_nxt[w_lr_idx]    = req_id_i;
          w_gran_nxt[w_lr_idx]  = w_req_gran;
          w_age_nxt[w_lr_idx]   = '0;
          if (w_evict)
            w_ptr_nxt = (r_evict_ptr == c_idx_w'(NUM_SLOTS - 1)) ? '0
                                                                 : r_evict_ptr + c_idx_w'(1);
        end
        c_op_sc: begin
          for (int i = 0; i < NUM_SLOTS; i++)
            if (w_hit_id[i] || (w_sc_ok && w_hit_gran[i])) w_valid_nxt[i] = 1'b0;
        end
        c_op_wr: begin
          for (int i = 0; i < NUM_SLOTS; i++)
            if (w_hit_gran[i]) w_valid_nxt[i] = 1'b0;
        end
        default: begin
          w_valid_nxt = '0;
          w_ptr_nxt   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_valid     <= '0;
      r_evict_ptr <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_sc_ok <= 1'b0;
      r_rsp_id    <= '0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
        r_id[i]   <= '0;
        r_gran[i] <= '0;
        r_age[i]  <= '0;
      end
    end else begin
      r_valid     <= w_valid_nxt;
      r_id        <= w_id_nxt;
      r_gran      <= w_gran_nxt;
      r_age       <= w_age_nxt;
      r_evict_ptr <= w_ptr_nxt;
      if (w_accept) begin
        r_rsp_valid <= 1'b1;
        r_rsp_sc_ok <= (req_op_i == c_op_sc) && w_sc_ok;
        r_rsp_id    <= req_id_i;
      end else if (rsp_ready_i) begin
        r_rsp_valid <= 1'b0;
      end
    end
  end

  assign rsp_valid_o = r_rsp_valid;
  assign rsp_sc_ok_o = r_rsp_sc_ok;
  assign rsp_id_o    = r_rsp_id;
  assign occupancy_o = w_occ;

endmodule

`default_nettype wire

// File: tb/tb_axi_riscv_lrsc_table.sv
// ---------------------------------------------------------------------------
// tb_axi_riscv_lrsc_table : scoreboard bench for axi_riscv_lrsc_table.
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module tb_axi_riscv_lrsc_table;

  localparam int ADDR_WIDTH     = 64;
  localparam int ID_WIDTH       = 5;
  localparam int NUM_SLOTS      = 4;
  localparam int RES_GRANULE    = 8;
  localparam int TIMEOUT_CYCLES = 16;
  localparam int OCC_W          = $clog2(NUM_SLOTS + 1);

  localparam logic [1:0] OP_LR  = 2'b00;
  localparam logic [1:0] OP_SC  = 2'b01;
  localparam logic [1:0] OP_WR  = 2'b10;
  localparam logic [1:0] OP_CLR = 2'b11;

  logic                  clk = 1'b0;
  logic                  rst = 1'b0;
  logic                  req_valid = 1'b0;
  logic                  req_ready;
  logic [1:0]            req_op = 2'b00;
  logic [ID_WIDTH-1:0]   req_id = '0;
  logic [ADDR_WIDTH-1:0] req_addr = '0;
  logic                  rsp_valid;
  logic                  rsp_ready = 1'b1;
  logic                  rsp_sc_ok;
  logic [ID_WIDTH-1:0]   rsp_id;
  logic [OCC_W-1:0]      occ;

  int n_total = 0;
  int n_bad   = 0;
  logic [ID_WIDTH:0] exp_q[$];

  axi_riscv_lrsc_table #(
    .ADDR_WIDTH    (ADDR_WIDTH),
    .ID_WIDTH      (ID_WIDTH),
    .NUM_SLOTS     (NUM_SLOTS),
    .RES_GRANULE   (RES_GRANULE),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .req_valid_i(req_valid),
    .req_ready_o(req_ready),
    .req_op_i   (req_op),
    .req_id_i   (req_id),
    .req_addr_i (req_addr),
    .rsp_valid_o(rsp_valid),
    .rsp_ready_i(rsp_ready),
    .rsp_sc_ok_o(rsp_sc_ok),
    .rsp_id_o   (rsp_id),
    .occupancy_o(occ)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Issue one request; the expected response is queued at the accept edge.
  task automatic do_req(input logic [1:0] op, input int id, input logic [63:0] addr,
                        input logic ok);
    int waits = 0;
    req_valid = 1'b1;
    req_op    = op;
    req_id    = ID_WIDTH'(id);
    req_addr  = addr;
    @(negedge clk);
    while (!req_ready && waits < 50) begin
      waits++;
      @(negedge clk);
    end
    if (!req_ready) begin
      chk("accept_timeout", 64'(req_ready), 64'd1);
      @(posedge clk);
    end else begin
      @(posedge clk);
      exp_q.push_back({ID_WIDTH'(id), ok});
    end
    #1;
    req_valid = 1'b0;
  endtask

  // Handshake completes at the next rising edge; inputs are stable since the
  // driver only changes them just after a rising edge.
  always @(negedge clk) begin
    if (!rst && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0)
        chk("rsp_unexpected", 64'(exp_q.size()), 64'd1);
      else
        chk("rsp", 64'({rsp_id, rsp_sc_ok}), 64'(exp_q.pop_front()));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    #1 rst = 1'b1;
    #11;
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_rsp_id",    64'({rsp_id, rsp_sc_ok}), 64'd0);
    chk("rst_occ",       64'(occ), 64'd0);
    chk("rst_req_ready", 64'(req_ready), 64'd1);
    @(posedge clk); #1;
    rst = 1'b0;

    // LR then SC in the same granule
    do_req(OP_LR, 3, 64'h1000, 1'b0);
    chk("lr_occ1", 64'(occ), 64'd1);
    do_req(OP_SC, 3, 64'h1004, 1'b1);
    chk("sc_occ0", 64'(occ), 64'd0);

    // plain write from another ID kills the reservation
    do_req(OP_LR, 3, 64'h1000, 1'b0);
    do_req(OP_WR, 5, 64'h1007, 1'b0);
    chk("wr_occ0", 64'(occ), 64'd0);
    do_req(OP_SC, 3, 64'h1000, 1'b0);

    // fill, evict slot 0, then SCs
    for (int i = 0; i < 4; i++) do_req(OP_LR, i, 64'((i + 1) * 256), 1'b0);
    chk("fill_occ4", 64'(occ), 64'd4);
    do_req(OP_LR, 4, 64'h500, 1'b0);
    chk("evict_occ4", 64'(occ), 64'd4);
    do_req(OP_SC, 0, 64'h100, 1'b0);
    do_req(OP_SC, 1, 64'h200, 1'b1);
    chk("evict_sc_occ3", 64'(occ), 64'd3);
    do_req(OP_CLR, 9, 64'h0, 1'b0);
    chk("clr_occ0", 64'(occ), 64'd0);

    // clear-all must return the eviction pointer to slot 0
    for (int i = 0; i < 4; i++) do_req(OP_LR, i, 64'((i + 1) * 256), 1'b0);
    do_req(OP_LR, 4, 64'h500, 1'b0);
    do_req(OP_SC, 1, 64'h200, 1'b1);
    do_req(OP_SC, 0, 64'h100, 1'b0);
    do_req(OP_CLR, 0, 64'h0, 1'b0);

    // second LR from same ID moves the reservation
    do_req(OP_LR, 7, 64'h3000, 1'b0);
    do_req(OP_LR, 7, 64'h4000, 1'b0);
    chk("ovw_occ1", 64'(occ), 64'd1);
    do_req(OP_SC, 7, 64'h3000, 1'b0);
    chk("ovw_sc_occ0", 64'(occ), 64'd0);

    // successful SC frees other IDs' slots in the same granule
    do_req(OP_LR, 1, 64'h5000, 1'b0);
    do_req(OP_LR, 2, 64'h5004, 1'b0);
    chk("gran_occ2", 64'(occ), 64'd2);
    do_req(OP_SC, 1, 64'h5000, 1'b1);
    chk("gran_sc_occ0", 64'(occ), 64'd0);
    do_req(OP_SC, 2, 64'h5004, 1'b0);

    // timeout: last usable edge is E0+16
    do_req(OP_LR, 2, 64'h2000, 1'b0);
    tick(15);
    chk("to_occ_alive", 64'(occ), 64'd1);
    do_req(OP_SC, 2, 64'h2000, 1'b1);
    do_req(OP_LR, 2, 64'h2000, 1'b0);
    tick(15);
    chk("to_occ_e15", 64'(occ), 64'd1);
    tick(1);
    chk("to_occ_e16", 64'(occ), 64'd0);
    do_req(OP_SC, 2, 64'h2000, 1'b0);

    // LR on the expiring edge keeps the slot
    do_req(OP_LR, 2, 64'h2000, 1'b0);
    tick(15);
    do_req(OP_LR, 2, 64'h2000, 1'b0);
    chk("lr_vs_to_occ", 64'(occ), 64'd1);
    do_req(OP_SC, 2, 64'h2000, 1'b1);
    tick(1);

    // response backpressure
    rsp_ready = 1'b0;
    do_req(OP_LR, 1, 64'h600, 1'b0);
    req_valid = 1'b1;
    req_op    = OP_SC;
    req_id    = ID_WIDTH'(1);
    req_addr  = 64'h600;
    for (int c = 0; c < 5; c++) begin
      chk("bp_req_ready", 64'(req_ready), 64'd0);
      chk("bp_rsp_hold",  64'({rsp_valid, rsp_id, rsp_sc_ok}), 64'({1'b1, 5'd1, 1'b0}));
      tick(1);
    end
    rsp_ready = 1'b1;
    do_req(OP_SC, 1, 64'h600, 1'b1);
    chk("bp_next_rsp", 64'(rsp_valid), 64'd1);
    tick(1);

    // asynchronous reset mid-operation
    do_req(OP_LR, 1, 64'h700, 1'b0);
    do_req(OP_LR, 2, 64'h800, 1'b0);
    rsp_ready = 1'b0;
    chk("ar_occ2", 64'(occ), 64'd2);
    chk("ar_pending", 64'(rsp_valid), 64'd1);
    #2 rst = 1'b1;
    #1;
    chk("ar_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("ar_occ0",      64'(occ), 64'd0);
    chk("ar_req_ready", 64'(req_ready), 64'd1);
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    rsp_ready = 1'b1;
    tick(1);
    do_req(OP_SC, 1, 64'h700, 1'b0);

    tick(3);
    chk("drain", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/axi_riscv_lrsc_table.md
AXI_RISCV_LRSC_TABLE -- requirements
Module: axi_riscv_lrsc_table

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 64, request address width in bits.
REQ-002 SHALL have parameter ID_WIDTH, default 5, requester (AXI ID) width in bits.
REQ-003 SHALL have parameter NUM_SLOTS, default 4, number of concurrent reservations; legal range >= 1.
REQ-004 SHALL have parameter RES_GRANULE, default 8, reservation granule in bytes; power of two >= 1.
REQ-005 SHALL have parameter TIMEOUT_CYCLES, default 0, reservation lifetime in cycles; 0 disables timeout.
REQ-006 SHALL have port clk_i  input  1  single clock, all state on rising edge.
REQ-007 SHALL have port rst_i  input  1  asynchronous, active-high reset.
REQ-008 SHALL have port req_valid_i  input  1  request valid.
REQ-009 SHALL have port req_ready_o  output  1  request ready.
REQ-010 SHALL have port req_op_i  input  2  00 LR, 01 SC, 10 plain write, 11 clear-all.
REQ-011 SHALL have port req_id_i  input  ID_WIDTH  requester ID.
REQ-012 SHALL have port req_addr_i  input  ADDR_WIDTH  byte address.
REQ-013 SHALL have port rsp_valid_o  output  1  response valid.
REQ-014 SHALL have port rsp_ready_i  input  1  response ready.
REQ-015 SHALL have port rsp_sc_ok_o  output  1  SC succeeded; 0 for all non-SC ops.
REQ-016 SHALL have port rsp_id_o  output  ID_WIDTH  ID of the request being answered.
REQ-017 SHALL have port occupancy_o  output  $clog2(NUM_SLOTS+1)  number of valid slots.

Function
REQ-018 SHALL accept a request on a rising edge with req_valid_i && req_ready_o; req_ready_o = !rsp_valid_o || rsp_ready_i.
REQ-019 SHALL register exactly one response per accepted request, rsp_valid_o high from the cycle after acceptance; sustained throughput one request per cycle.
REQ-020 SHALL hold rsp_valid_o, rsp_sc_ok_o and rsp_id_o stable while rsp_valid_o && !rsp_ready_i.
REQ-021 SHALL give each slot states FREE and RESERVED, holding ID, granule address (req_addr_i >> log2(RES_GRANULE)) and age counter.
REQ-022 SHALL apply every table update at the accept edge, so the next request sees the updated table.
REQ-023 LR: SHALL overwrite the slot already RESERVED for req_id_i (new granule, age 0); else fill the lowest-index FREE slot; else evict the slot at the round-robin pointer.
REQ-024 SHALL advance the eviction pointer only on eviction, wrapping NUM_SLOTS-1 -> 0.
REQ-025 SC: SHALL succeed iff a RESERVED slot matches both req_id_i and granule; SHALL free the req_id_i slot whether or not it succeeds.
REQ-026 SC success SHALL also free every other slot matching the same granule.
REQ-027 Plain write: SHALL free every slot matching the granule, any ID; no slot is allocated.
REQ-028 Clear-all: SHALL free every slot and reset the eviction pointer to 0.
REQ-029 With TIMEOUT_CYCLES>0: age SHALL increment each edge while RESERVED; a slot with age==TIMEOUT_CYCLES-1 SHALL go FREE on that edge.
REQ-030 Usable lifetime: a slot set by LR at edge E0 SHALL match requests accepted at edges E0+1..E0+TIMEOUT_CYCLES.
REQ-031 Simultaneous timeout and LR on the same slot: LR SHALL win (slot RESERVED, age 0).
REQ-032 Simultaneous timeout and SC: SC SHALL see the pre-edge state.
REQ-033 occupancy_o SHALL equal the popcount of RESERVED slots in registered state (combinational).
REQ-034 At most one slot SHALL be RESERVED per ID at any time.

Reset
REQ-035 While rst_i is high: all slots FREE, ages 0, eviction pointer 0, rsp_valid_o=0, rsp_sc_ok_o=0, rsp_id_o=0, occupancy_o=0, req_ready_o=1.
REQ-036 Assertion mid-operation SHALL discard any pending response and all reservations immediately, without waiting for a clock edge.

Verification (NUM_SLOTS=4, RES_GRANULE=8, TIMEOUT_CYCLES=16)
REQ-037 LR id3 0x1000, then SC id3 0x1004 -> rsp_sc_ok_o=1, rsp_id_o=3; occupancy_o 1 -> 0.
REQ-038 LR id3 0x1000, then write id5 0x1007, then SC id3 0x1000 -> occupancy_o=0 after write; SC rsp_sc_ok_o=0.
REQ-039 LR ids 0..4 at 0x100,0x200,...,0x500 -> id4 evicts slot 0; SC id0 0x100 fails; SC id1 0x200 succeeds; occupancy_o=4 before the SCs.
REQ-040 LR id2 0x2000 at E0; SC accepted at E0+16 -> ok=1; repeated with SC at E0+17 -> ok=0 and occupancy_o=0 from E0+16.
REQ-041 Hold rsp_ready_i=0 after one accept -> req_ready_o=0, response stable 5 cycles; raise rsp_ready_i -> same-cycle new accept, next response follows.
REQ-042 Two slots RESERVED, rsp_valid_o=1, assert rst_i between edges -> rsp_valid_o=0 and occupancy_o=0 before the next edge; SC afterwards fails.
